// File: rtl/spi_reg_cmd_decoder.sv
// spi_reg_cmd_decoder
//   Turns 5-byte SPI command frames (ADDR, D0, D1, D2, CHK) into a register
//   write strobe. CHK must equal ADDR^D0^D1^D2, and D2[7:1] must be zero.
//   A frame is aborted if cs_n rises mid-frame or if the link stalls for
//   TIMEOUT_CYCLES cycles. Either an abort or a rejected frame gives a
//   one-cycle frame_error pulse.
//
// Ports
//   sysClk          in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   rx_byte[7:0]    in   byte from the SPI slave
//   rx_byte_valid   in   one-cycle strobe qualifying rx_byte
//   cs_n            in   chip select, already synchronised; low = frame active
//   reg_addr[7:0]   out  last good register address
//   reg_data[16:0]  out  last good register data {D2[0], D1, D0}
//   reg_input_valid out  one-cycle strobe, 1 cycle after a good CHK
//   frame_error     out  one-cycle strobe on an aborted or rejected frame
//   err_count[7:0]  out  saturating count of frame_error pulses
//   busy            out  high while a frame is in progress
//
// state    | meaning
// ---------+-------------------------------------------
// IDLE     | waiting for the ADDR byte
// GOT_ADDR | ADDR held, waiting for D0
// GOT_D0   | D0 held, waiting for D1
// GOT_D1   | D1 held, waiting for D2
// GOT_D2   | D2 held, waiting for CHK

module spi_reg_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        sysClk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    input  logic        cs_n,
    output logic [7:0]  reg_addr,
    output logic [16:0] reg_data,
    output logic        reg_input_valid,
    output logic        frame_error,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_ADDR = 3'd1,
        GOT_D0   = 3'd2,
        GOT_D1   = 3'd3,
        GOT_D2   = 3'd4
    } state_t;

    state_t        state_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    addr_q;
    logic [7:0]    d0_q;
    logic [7:0]    d1_q;
    logic          d2_bit_q;
    logic          rsvd_q;
    logic [7:0]    chk_q;
    logic [7:0]    reg_addr_q;
    logic [16:0]   reg_data_q;
    logic          reg_input_valid_q;
    logic          frame_error_q;
    logic [7:0]    err_count_q;

    logic          accept;
    logic          in_frame;
    logic [7:0]    err_count_d;

    assign accept      = rx_byte_valid && !cs_n;
    assign in_frame    = (state_q != IDLE);
    assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            tmo_q             <= '0;
            addr_q            <= '0;
            d0_q              <= '0;
            d1_q              <= '0;
            d2_bit_q          <= 1'b0;
            rsvd_q            <= 1'b0;
            chk_q             <= '0;
            reg_addr_q        <= '0;
            reg_data_q        <= '0;
            reg_input_valid_q <= 1'b0;
            frame_error_q     <= 1'b0;
            err_count_q       <= '0;
        end else begin
            reg_input_valid_q <= 1'b0;
            frame_error_q     <= 1'b0;

            // cs_n high outside IDLE means it rose mid-frame. This also
            // covers a CHK strobe in the same cycle, which is discarded.
            if (in_frame && cs_n) begin
                state_q       <= IDLE;
                tmo_q         <= '0;
                frame_error_q <= 1'b1;
                err_count_q   <= err_count_d;
            end else if (accept) begin
                // An accepted byte beats a timeout that would expire this cycle.
                tmo_q <= '0;
                unique case (state_q)
                    IDLE: begin
                        addr_q  <= rx_byte;
                        chk_q   <= rx_byte;
                        state_q <= GOT_ADDR;
                    end
                    GOT_ADDR: begin
                        d0_q    <= rx_byte;
                        chk_q   <= chk_q ^ rx_byte;
                        state_q <= GOT_D0;
                    end
                    GOT_D0: begin
                        d1_q    <= rx_byte;
                        chk_q   <= chk_q ^ rx_byte;
                        state_q <= GOT_D1;
                    end
                    GOT_D1: begin
                        d2_bit_q <= rx_byte[0];
                        rsvd_q   <= |rx_byte[7:1];
                        chk_q    <= chk_q ^ rx_byte;
                        state_q  <= GOT_D2;
                    end
                    GOT_D2: begin
                        state_q <= IDLE;
                        if ((chk_q == rx_byte) && !rsvd_q) begin
                            reg_addr_q        <= addr_q;
                            reg_data_q        <= {d2_bit_q, d1_q, d0_q};
                            reg_input_valid_q <= 1'b1;
                        end else begin
                            frame_error_q <= 1'b1;
                            err_count_q   <= err_count_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (in_frame) begin
                if (tmo_q == TMO_LAST) begin
                    state_q       <= IDLE;
                    tmo_q         <= '0;
                    frame_error_q <= 1'b1;
                    err_count_q   <= err_count_d;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign reg_addr        = reg_addr_q;
    assign reg_data        = reg_data_q;
    assign reg_input_valid = reg_input_valid_q;
    assign frame_error     = frame_error_q;
    assign err_count       = err_count_q;
    assign busy            = in_frame;

endmodule

// File: doc/spi_reg_cmd_decoder.md
SPI_REG_CMD_DECODER -- requirements
Module: spi_reg_cmd_decoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning idle cycles allowed inside a frame before abort.
REQ-002 sysClk  input  1  system clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rx_byte  input  8  byte received from SPI slave interface.
REQ-005 rx_byte_valid  input  1  one-cycle strobe qualifying rx_byte.
REQ-006 cs_n  input  1  SPI chip select, already synchronised to sysClk; low = frame active.
REQ-007 reg_addr  output  8  decoded register address.
REQ-008 reg_data  output  17  decoded register data.
REQ-009 reg_input_valid  output  1  one-cycle strobe qualifying reg_addr/reg_data.
REQ-010 frame_error  output  1  one-cycle strobe on any aborted or rejected frame.
REQ-011 err_count  output  8  saturating count of frame_error pulses.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Frame format SHALL be 5 bytes in order: ADDR, D0, D1, D2, CHK, all while cs_n low.
REQ-014 State machine SHALL have states IDLE, GOT_ADDR, GOT_D0, GOT_D1, GOT_D2; each accepted byte advances one state; the CHK byte returns to IDLE.
REQ-015 A byte SHALL be accepted only when rx_byte_valid=1 and cs_n=0; bytes with cs_n=1 SHALL be ignored without error in IDLE.
REQ-016 Decoded data SHALL be reg_data = {D2[0], D1, D0}; D2[7:1] are reserved and SHALL be zero.
REQ-017 Expected checksum SHALL be ADDR ^ D0 ^ D1 ^ D2 (8-bit XOR).
REQ-018 On the edge sampling CHK, if checksum matches and D2[7:1]==0, reg_addr/reg_data SHALL load and reg_input_valid SHALL be 1 for exactly the following cycle (latency 1 cycle from CHK strobe).
REQ-019 reg_addr/reg_data SHALL hold their last good values until the next good frame; rejected frames SHALL NOT alter them.
REQ-020 Checksum mismatch or nonzero D2[7:1] SHALL pulse frame_error for one cycle (same timing as REQ-018) and return to IDLE with no reg_input_valid.
REQ-021 cs_n rising while state is not IDLE SHALL abort: frame_error pulse, state IDLE; a byte strobe in the same cycle SHALL be discarded.
REQ-022 Timeout counter SHALL clear on every accepted byte and in IDLE; when TIMEOUT_CYCLES consecutive non-IDLE cycles pass with no accepted byte, the block SHALL abort with frame_error and return to IDLE.
REQ-023 A byte accepted in the same cycle the timeout would expire SHALL win; no abort.
REQ-024 err_count SHALL increment on each frame_error and saturate at 255 (no wrap).
REQ-025 Bytes after CHK while cs_n stays low SHALL start a new frame (back-to-back frames, no gap cycle required).
REQ-026 CHK strobe and cs_n rise in the same cycle SHALL be treated as abort (REQ-021), not frame completion.

Reset
REQ-027 While rst_n=0 the block SHALL immediately force state IDLE, reg_addr=0, reg_data=0, reg_input_valid=0, frame_error=0, err_count=0, busy=0, timeout counter 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no frame_error; first byte after release SHALL be treated as ADDR.

Verification
REQ-029 Bytes 08,01,00,00,09 with cs_n low -> one cycle after CHK strobe: reg_input_valid=1, reg_addr=0x08, reg_data=0x00001; busy=0.
REQ-030 Bytes 09,34,12,01,2E -> reg_addr=0x09, reg_data=0x11234; then 09,34,12,01,2F -> frame_error pulse, err_count=1, reg_data stays 0x11234, no reg_input_valid.
REQ-031 Bytes 08,01,00,02,0B (reserved bit set) -> frame_error pulse, no reg_input_valid.
REQ-032 Bytes 08,01 then cs_n high -> frame_error pulse on that edge, busy=0; next frame 08,01,00,00,09 decodes correctly.
REQ-033 TIMEOUT_CYCLES=16: byte 08 then 16 idle cycles -> frame_error at 16th cycle; repeat with byte arriving exactly on cycle 16 -> no abort; 300 forced errors -> err_count=255.
REQ-034 Two back-to-back good frames within one cs_n low window -> two reg_input_valid pulses with correct values; rst_n pulse mid-frame -> all outputs 0, no frame_error.
